// File: rtl/mt9v032_pkg.sv
// Shared MT9V032 LVDS packet definitions, used by both the transmitter and the receiver.
package mt9v032_pkg;

    localparam int PKT_BITS  = 12;
    localparam int DATA_BITS = 10;

    localparam logic START_BIT = 1'b1;
    localparam logic STOP_BIT  = 1'b0;

    // Pixel values reserved by the sensor link; clamping keeps pixels off them.
    localparam logic [DATA_BITS-1:0] RESERVED_LO = 10'h000;
    localparam logic [DATA_BITS-1:0] RESERVED_HI = 10'h3FF;

    // Source of the word loaded into a slot.
    typedef enum logic [1:0] {
        SLOT_IDLE  = 2'd0,
        SLOT_PIXEL = 2'd1,
        SLOT_TRAIN = 2'd2
    } slot_kind_e;

    // Assemble {stop, data, start}, where bit 0 goes out first.
    // With msb_first the data field is reversed so d9 follows the start bit.
    function automatic logic [PKT_BITS-1:0] build_packet(
        input logic [DATA_BITS-1:0] data,
        input logic                 msb_first
    );
        logic [DATA_BITS-1:0] ordered;
        ordered = data;
        for (int i = 0; i < DATA_BITS; i++) begin
            ordered[i] = msb_first ? data[DATA_BITS-1-i] : data[i];
        end
        return {STOP_BIT, ordered, START_BIT};
    endfunction

endpackage

// File: rtl/mt9v032_lvds_tx_buf.sv
// One-entry valid/ready holding register between the pixel source and the word slots.
// Reserved pixel values are remapped as they are written, when clamping is enabled.
module mt9v032_lvds_tx_buf
    import mt9v032_pkg::*;
#(
    parameter bit CLAMP = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DATA_BITS-1:0] in_data,
    input  logic                 drain_slot,
    output logic                 buf_valid,
    output logic [DATA_BITS-1:0] buf_data
);

    logic                 buf_valid_q, buf_valid_d;
    logic [DATA_BITS-1:0] buf_data_q, buf_data_d;
    logic [DATA_BITS-1:0] clamped;

    // Move reserved pixel values one step into the legal range.
    always_comb begin
        clamped = in_data;
        if (CLAMP) begin
            if (in_data == RESERVED_LO) begin
                clamped = RESERVED_LO + 10'd1;
            end else if (in_data == RESERVED_HI) begin
                clamped = RESERVED_HI - 10'd1;
            end
        end
    end

    // Accept when empty or when the current slot drains the entry; a refill wins over a drain.
    always_comb begin
        in_ready    = !rst && (!buf_valid_q || drain_slot);
        buf_valid_d = buf_valid_q;
        buf_data_d  = buf_data_q;
        if (in_valid && in_ready) begin
            buf_valid_d = 1'b1;
            buf_data_d  = clamped;
        end else if (drain_slot) begin
            buf_valid_d = 1'b0;
        end
    end

    // Holding register; reset flushes any pending pixel.
    always_ff @(posedge clk) begin
        if (rst) begin
            buf_valid_q <= 1'b0;
            buf_data_q  <= '0;
        end else begin
            buf_valid_q <= buf_valid_d;
            buf_data_q  <= buf_data_d;
        end
    end

    assign buf_valid = buf_valid_q;
    assign buf_data  = buf_data_q;

endmodule

// File: rtl/mt9v032_lvds_tx.sv
// MT9V032 LVDS emulator: one 12-bit packet per 12 clocks, one bit per clock.
// Each slot carries the training word, the buffered pixel or the idle word.
module mt9v032_lvds_tx
    import mt9v032_pkg::*;
#(
    parameter bit                   SWAP       = 1'b0,
    parameter bit                   MSB_FIRST  = 1'b0,
    parameter logic [DATA_BITS-1:0] TRAIN_WORD = 10'h0F0,
    parameter logic [DATA_BITS-1:0] IDLE_WORD  = 10'h000,
    parameter bit                   CLAMP      = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DATA_BITS-1:0] in_data,
    input  logic                 train,
    output logic                 out_bit,
    output logic                 word_start,
    output logic                 train_active,
    output logic                 idle_slot
);

    logic [3:0]          bit_cnt_q, bit_cnt_d;
    logic                started_q, started_d;
    logic [PKT_BITS-1:0] shifter_q, shifter_d;
    logic                pkt_train_q, pkt_train_d;
    logic                pkt_idle_q, pkt_idle_d;
    logic                out_bit_q, out_bit_d;
    logic                word_start_q, word_start_d;
    logic                train_active_q, train_active_d;
    logic                idle_slot_q, idle_slot_d;

    logic                 load_now;
    logic                 drain_slot;
    logic                 buf_valid;
    logic [DATA_BITS-1:0] buf_data;
    slot_kind_e           slot_kind;

    // A slot boundary is the first clock out of reset and every twelfth clock after.
    assign load_now   = !started_q || (bit_cnt_q == 4'd11);
    assign drain_slot = load_now && !train;

    mt9v032_lvds_tx_buf #(
        .CLAMP (CLAMP)
    ) u_buf (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .drain_slot (drain_slot),
        .buf_valid  (buf_valid),
        .buf_data   (buf_data)
    );

    // Word priority at a slot boundary: training, then buffered pixel, then idle.
    always_comb begin
        slot_kind = SLOT_IDLE;
        if (train) begin
            slot_kind = SLOT_TRAIN;
        end else if (buf_valid) begin
            slot_kind = SLOT_PIXEL;
        end
    end

    // Slot counter, packet shifter and the registered serial outputs.
    always_comb begin
        started_d   = 1'b1;
        bit_cnt_d   = bit_cnt_q + 4'd1;
        shifter_d   = shifter_q;
        pkt_train_d = pkt_train_q;
        pkt_idle_d  = pkt_idle_q;
        if (load_now) begin
            bit_cnt_d = 4'd0;
            case (slot_kind)
                SLOT_TRAIN: begin
                    shifter_d   = build_packet(TRAIN_WORD, MSB_FIRST);
                    pkt_train_d = 1'b1;
                    pkt_idle_d  = 1'b0;
                end
                SLOT_PIXEL: begin
                    shifter_d   = build_packet(buf_data, MSB_FIRST);
                    pkt_train_d = 1'b0;
                    pkt_idle_d  = 1'b0;
                end
                default: begin
                    shifter_d   = build_packet(IDLE_WORD, MSB_FIRST);
                    pkt_train_d = 1'b0;
                    pkt_idle_d  = 1'b1;
                end
            endcase
        end
        out_bit_d      = started_q ? (shifter_q[bit_cnt_q] ^ SWAP) : SWAP;
        word_start_d   = started_q && (bit_cnt_q == 4'd0);
        train_active_d = started_q && pkt_train_q;
        idle_slot_d    = started_q && (bit_cnt_q == 4'd0) && pkt_idle_q;
    end

    // State and output registers; reset aborts the packet in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt_q      <= 4'd0;
            started_q      <= 1'b0;
            shifter_q      <= '0;
            pkt_train_q    <= 1'b0;
            pkt_idle_q     <= 1'b0;
            out_bit_q      <= SWAP;
            word_start_q   <= 1'b0;
            train_active_q <= 1'b0;
            idle_slot_q    <= 1'b0;
        end else begin
            bit_cnt_q      <= bit_cnt_d;
            started_q      <= started_d;
            shifter_q      <= shifter_d;
            pkt_train_q    <= pkt_train_d;
            pkt_idle_q     <= pkt_idle_d;
            out_bit_q      <= out_bit_d;
            word_start_q   <= word_start_d;
            train_active_q <= train_active_d;
            idle_slot_q    <= idle_slot_d;
        end
    end

    assign out_bit      = out_bit_q;
    assign word_start   = word_start_q;
    assign train_active = train_active_q;
    assign idle_slot    = idle_slot_q;

endmodule
